// File: rtl/led_display_pkg.sv
// Shared types and constants for the LED display frame-RAM path.
package led_display_pkg;

  localparam int PIX_AW   = 11;   // 64x32 pixels
  localparam int RAM_AW   = 16;   // frame RAM address width
  localparam int DATA_W   = 24;   // 8:8:8 RGB
  localparam int STREAK_W = 8;    // read-streak counter width

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FORCE_WR
  } arb_state_t;

endpackage

// File: rtl/frame_ram_arbiter_if.sv
// Requester + RAM bus of the frame RAM arbiter. slave = arbiter side,
// master = requesters / RAM side.
interface frame_ram_arbiter_if #(
  parameter int PIX_AW = led_display_pkg::PIX_AW,
  parameter int RAM_AW = led_display_pkg::RAM_AW,
  parameter int DATA_W = led_display_pkg::DATA_W
);
  import led_display_pkg::*;

  // read port (display scan)
  logic              rd_req_in;
  logic [PIX_AW-1:0] rd_addr_in;
  logic              rd_gnt_out;
  logic              rd_data_valid_out;
  logic [DATA_W-1:0] rd_data_out;
  // write port (pixel writer)
  logic              wr_valid_in;
  logic [PIX_AW-1:0] wr_addr_in;
  logic [DATA_W-1:0] wr_data_in;
  logic              wr_ready_out;
  // bank control
  logic              frame_sync_in;
  logic              swap_req_in;
  logic              swap_done_out;
  // frame RAM
  logic              ram_enable_out;
  logic              ram_write_enable_out;
  logic [RAM_AW-1:0] ram_addr_out;
  logic [DATA_W-1:0] ram_wdata_out;
  logic [DATA_W-1:0] ram_rdata_in;

  modport slave (
    input  rd_req_in, rd_addr_in, wr_valid_in, wr_addr_in, wr_data_in,
           frame_sync_in, swap_req_in, ram_rdata_in,
    output rd_gnt_out, rd_data_valid_out, rd_data_out, wr_ready_out,
           swap_done_out, ram_enable_out, ram_write_enable_out,
           ram_addr_out, ram_wdata_out
  );

  modport master (
    output rd_req_in, rd_addr_in, wr_valid_in, wr_addr_in, wr_data_in,
           frame_sync_in, swap_req_in, ram_rdata_in,
    input  rd_gnt_out, rd_data_valid_out, rd_data_out, wr_ready_out,
           swap_done_out, ram_enable_out, ram_write_enable_out,
           ram_addr_out, ram_wdata_out
  );

endinterface

// File: rtl/frame_ram_rd_pipe.sv
// Read-return pipeline: valid tags follow each accepted read through the
// command register and RAM_LATENCY RAM stages; data is held between beats.
module frame_ram_rd_pipe #(
  parameter int RAM_LATENCY = 1,
  parameter int DATA_W      = 24
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              i_rd_accept,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data
);
  import led_display_pkg::*;

  // [0] lines up with the RAM command cycle, [RAM_LATENCY] with valid douta
  logic [RAM_LATENCY:0] r_vld_pipe;
  logic [DATA_W-1:0]    r_rd_data;

  // shift tags, capture douta on each returning beat; reset drops in-flight reads
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_vld_pipe <= '0;
      r_rd_data  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RAM_LATENCY-1:0], i_rd_accept};
      if (r_vld_pipe[RAM_LATENCY]) r_rd_data <= i_ram_rdata;
    end
  end

  // douta is already a RAM register output; present it on the valid beat
  // so the beat lands at t+1+RAM_LATENCY, then hold the captured copy
  assign o_rd_valid = r_vld_pipe[RAM_LATENCY];
  assign o_rd_data  = r_vld_pipe[RAM_LATENCY] ? i_ram_rdata : r_rd_data;

endmodule

// File: rtl/frame_ram_arbiter.sv
// Frame RAM arbiter: shares the single-port frame RAM between the display
// scan reader (priority) and the pixel writer, one command per cycle, with
// a read-streak guard so a waiting write is never starved.
// Optional double buffering: define FRAME_DOUBLE_BUFFER_EN.
module frame_ram_arbiter #(
  parameter int PIX_AW        = led_display_pkg::PIX_AW,
  parameter int RAM_AW        = led_display_pkg::RAM_AW,
  parameter int DATA_W        = led_display_pkg::DATA_W,
  parameter int RAM_LATENCY   = 1,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic                clk_in,
  input  logic                reset_in,
  frame_ram_arbiter_if.slave  arb_if
);
  import led_display_pkg::*;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                w_rd_gnt;
  logic                w_wr_gnt;
  logic [STREAK_W-1:0] r_streak;
  logic                w_rd_bank;
  logic                w_wr_bank;
  logic [RAM_AW-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

`ifdef FRAME_DOUBLE_BUFFER_EN
  logic r_front_bank;
  logic r_swap_pending;
  logic r_swap_done;
  logic w_swap_fire;

  // a sync with a swap pending (or requested in the same cycle) flips the bank
  assign w_swap_fire = arb_if.frame_sync_in & (r_swap_pending | arb_if.swap_req_in);

  // bank swap bookkeeping; grants in the sync cycle still see the old bank
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_front_bank   <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
    end else begin
      r_swap_done <= w_swap_fire;
      if (w_swap_fire) begin
        r_front_bank   <= ~r_front_bank;
        r_swap_pending <= 1'b0;
      end else if (arb_if.swap_req_in) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign w_rd_bank            = r_front_bank;
  assign w_wr_bank            = ~r_front_bank;
  assign arb_if.swap_done_out = r_swap_done;
`else
  logic w_unused_swap;

  // single buffer: everything lives in bank 0, swap controls are inert
  assign w_unused_swap        = arb_if.frame_sync_in ^ arb_if.swap_req_in;
  assign w_rd_bank            = 1'b0;
  assign w_wr_bank            = 1'b0;
  assign arb_if.swap_done_out = 1'b0;
`endif

  // state register: holds the grant decision that becomes this cycle's RAM command
  always_ff @(posedge clk_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // arbitration: reads win unless a write has waited MAX_RD_STREAK reads
  always_comb begin
    w_state_nxt = S_IDLE;
    w_rd_gnt    = 1'b0;
    w_wr_gnt    = 1'b0;
    if (reset_in) begin
      w_state_nxt = S_IDLE;
    end else if (arb_if.rd_req_in && arb_if.wr_valid_in) begin
      if (r_streak == STREAK_W'(MAX_RD_STREAK)) w_state_nxt = S_FORCE_WR;
      else                                      w_state_nxt = S_RD;
    end else if (arb_if.rd_req_in) begin
      w_state_nxt = S_RD;
    end else if (arb_if.wr_valid_in) begin
      w_state_nxt = S_WR;
    end
    w_rd_gnt = (w_state_nxt == S_RD);
    w_wr_gnt = (w_state_nxt == S_WR) || (w_state_nxt == S_FORCE_WR);
  end

  assign arb_if.rd_gnt_out   = w_rd_gnt;
  assign arb_if.wr_ready_out = w_wr_gnt;

  // streak counts reads granted over a waiting write; any write or idle writer clears it
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_streak <= '0;
    end else if (!arb_if.wr_valid_in || w_wr_gnt) begin
      r_streak <= '0;
    end else if (w_rd_gnt && (r_streak != {STREAK_W{1'b1}})) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  // RAM command address/data: bank sampled at acceptance, held on idle cycles
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_rd_gnt) begin
      r_addr <= RAM_AW'({w_rd_bank, arb_if.rd_addr_in[PIX_AW-1:0]});
    end else if (w_wr_gnt) begin
      r_addr  <= RAM_AW'({w_wr_bank, arb_if.wr_addr_in[PIX_AW-1:0]});
      r_wdata <= arb_if.wr_data_in;
    end
  end

  assign arb_if.ram_enable_out       = (r_state != S_IDLE);
  assign arb_if.ram_write_enable_out = (r_state == S_WR) || (r_state == S_FORCE_WR);
  assign arb_if.ram_addr_out         = r_addr;
  assign arb_if.ram_wdata_out        = r_wdata;

  frame_ram_rd_pipe #(
    .RAM_LATENCY (RAM_LATENCY),
    .DATA_W      (DATA_W)
  ) u_rd_pipe (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .i_rd_accept (w_rd_gnt),
    .i_ram_rdata (arb_if.ram_rdata_in),
    .o_rd_valid  (arb_if.rd_data_valid_out),
    .o_rd_data   (arb_if.rd_data_out)
  );

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter: u_dut (RAM_LATENCY=1) and
// u_dut2 (RAM_LATENCY=2) each sit on a behavioural frame RAM.
module tb_frame_ram_arbiter;
  import led_display_pkg::*;

  logic clk_in = 1'b0;
  logic reset_in;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk_in = ~clk_in;

  frame_ram_arbiter_if #(.PIX_AW(PIX_AW), .RAM_AW(RAM_AW), .DATA_W(DATA_W)) if_a ();
  frame_ram_arbiter_if #(.PIX_AW(PIX_AW), .RAM_AW(RAM_AW), .DATA_W(DATA_W)) if_b ();

  frame_ram_arbiter #(.RAM_LATENCY(1), .MAX_RD_STREAK(8)) u_dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .arb_if   (if_a)
  );

  frame_ram_arbiter #(.RAM_LATENCY(2), .MAX_RD_STREAK(8)) u_dut2 (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .arb_if   (if_b)
  );

  // behavioural frame RAM (low 12 address bits cover both banks)
  logic [23:0] mem [0:4095];
  logic [23:0] q_b1;

  always @(posedge clk_in) begin
    if (if_a.ram_enable_out) begin
      if (if_a.ram_write_enable_out) mem[if_a.ram_addr_out[11:0]] <= if_a.ram_wdata_out;
      else                           if_a.ram_rdata_in <= mem[if_a.ram_addr_out[11:0]];
    end
    if (if_b.ram_enable_out && !if_b.ram_write_enable_out) q_b1 <= mem[if_b.ram_addr_out[11:0]];
    if_b.ram_rdata_in <= q_b1;
  end

  function automatic logic [23:0] pat(input int a);
    logic [11:0] v;
    v = 12'(a);
    return {v, ~v};
  endfunction

`ifdef FRAME_DOUBLE_BUFFER_EN
  localparam logic WR_FLIP = 1'b1;
`else
  localparam logic WR_FLIP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    if_a.rd_req_in = 1'b0; if_a.rd_addr_in = '0;
    if_a.wr_valid_in = 1'b0; if_a.wr_addr_in = '0; if_a.wr_data_in = '0;
    if_a.frame_sync_in = 1'b0; if_a.swap_req_in = 1'b0;
    if_b.rd_req_in = 1'b0; if_b.rd_addr_in = '0;
    if_b.wr_valid_in = 1'b0; if_b.wr_addr_in = '0; if_b.wr_data_in = '0;
    if_b.frame_sync_in = 1'b0; if_b.swap_req_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"},   32'(if_a.ram_enable_out), 0);
    check({tag, "_wea"},   32'(if_a.ram_write_enable_out), 0);
    check({tag, "_addr"},  32'(if_a.ram_addr_out), 0);
    check({tag, "_wdata"}, 32'(if_a.ram_wdata_out), 0);
    check({tag, "_vld"},   32'(if_a.rd_data_valid_out), 0);
    check({tag, "_data"},  32'(if_a.rd_data_out), 0);
    check({tag, "_rgnt"},  32'(if_a.rd_gnt_out), 0);
    check({tag, "_wrdy"},  32'(if_a.wr_ready_out), 0);
    check({tag, "_swap"},  32'(if_a.swap_done_out), 0);
  endtask

  // one read on u_dut: grant at t, command at t+1, data at t+2, held at t+3
  task automatic single_read(input logic [10:0] a, input logic bank,
                             input logic [23:0] expd, input logic exp_done);
    tick();
    if_a.rd_req_in = 1'b1; if_a.rd_addr_in = a;
    #1;
    check("sr_gnt",  32'(if_a.rd_gnt_out), 1);
    check("sr_wrdy", 32'(if_a.wr_ready_out), 0);
    check("sr_swap_done", 32'(if_a.swap_done_out), 32'(exp_done));
    tick();
    if_a.rd_req_in = 1'b0;
    #1;
    check("sr_ena",  32'(if_a.ram_enable_out), 1);
    check("sr_wea",  32'(if_a.ram_write_enable_out), 0);
    check("sr_addr", 32'(if_a.ram_addr_out), 32'({bank, a}));
    check("sr_vld_early", 32'(if_a.rd_data_valid_out), 0);
    tick(); #1;
    check("sr_vld",  32'(if_a.rd_data_valid_out), 1);
    check("sr_data", 32'(if_a.rd_data_out), 32'(expd));
    tick(); #1;
    check("sr_vld_off",  32'(if_a.rd_data_valid_out), 0);
    check("sr_data_hold", 32'(if_a.rd_data_out), 32'(expd));
    check("sr_ena_off",  32'(if_a.ram_enable_out), 0);
  endtask

  initial begin
    pixel_t red;
    logic   exp_w;
    logic   va;
    logic   vb;
    red = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    for (int i = 0; i < 4096; i++) mem[i] = pat(i);
    mem[12'h805] = 24'h123456;

    // reset with both requests high: no grants, everything zero
    idle_inputs();
    reset_in = 1'b1;
    if_a.rd_req_in = 1'b1; if_a.wr_valid_in = 1'b1;
    repeat (3) tick();
    check("rst_rgnt", 32'(if_a.rd_gnt_out), 0);
    check("rst_wrdy", 32'(if_a.wr_ready_out), 0);
    tick();
    reset_in = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("rst");

`ifdef FRAME_DOUBLE_BUFFER_EN
    // swap request, then a frame sync 40 cycles later
    tick(); if_a.swap_req_in = 1'b1;
    tick(); if_a.swap_req_in = 1'b0;
    repeat (38) tick();
    tick(); if_a.frame_sync_in = 1'b1;
    #1;
    check("swap_done_early", 32'(if_a.swap_done_out), 0);
    if_a.frame_sync_in = 1'b0;
    // first cycle after the sync: done pulse, reads now hit bank 1
    single_read(11'h005, 1'b1, 24'h123456, 1'b1);
    // simultaneous request + sync swaps straight back to bank 0
    tick(); if_a.swap_req_in = 1'b1; if_a.frame_sync_in = 1'b1;
    tick(); if_a.swap_req_in = 1'b0; if_a.frame_sync_in = 1'b0;
    #1;
    check("swap_same_cycle", 32'(if_a.swap_done_out), 1);
    tick(); #1;
    check("swap_done_pulse", 32'(if_a.swap_done_out), 0);
`else
    // single buffer: swap controls do nothing
    tick(); if_a.swap_req_in = 1'b1; if_a.frame_sync_in = 1'b1;
    tick(); if_a.swap_req_in = 1'b0; if_a.frame_sync_in = 1'b0;
    #1;
    check("swap_ignored", 32'(if_a.swap_done_out), 0);
    single_read(11'h005, 1'b0, pat(12'h005), 1'b0);
`endif

    // lone write of red to 0x7FF with front bank 0
    tick();
    if_a.wr_valid_in = 1'b1; if_a.wr_addr_in = 11'h7FF; if_a.wr_data_in = red;
    #1;
    check("wr_rdy",  32'(if_a.wr_ready_out), 1);
    check("wr_rgnt", 32'(if_a.rd_gnt_out), 0);
    tick();
    if_a.wr_valid_in = 1'b0;
    #1;
    check("wr_ena",   32'(if_a.ram_enable_out), 1);
    check("wr_wea",   32'(if_a.ram_write_enable_out), 1);
    check("wr_addr",  32'(if_a.ram_addr_out), 32'({WR_FLIP, 11'h7FF}));
    check("wr_wdata", 32'(if_a.ram_wdata_out), 32'h00FF0000);
    tick(); #1;
    check("idle_ena",  32'(if_a.ram_enable_out), 0);
    check("idle_wea",  32'(if_a.ram_write_enable_out), 0);
    check("idle_addr_hold",  32'(if_a.ram_addr_out), 32'({WR_FLIP, 11'h7FF}));
    check("idle_wdata_hold", 32'(if_a.ram_wdata_out), 32'h00FF0000);
    // read back from the front bank: sees the write only in single-buffer mode
    single_read(11'h7FF, 1'b0, WR_FLIP ? pat(12'h7FF) : 24'hFF0000, 1'b0);

    // both requesters held: 8 reads then 1 forced write, repeating
    for (int c = 0; c < 27; c++) begin
      tick();
      if (c == 0) begin
        if_a.rd_req_in = 1'b1; if_a.rd_addr_in = 11'h020;
        if_a.wr_valid_in = 1'b1; if_a.wr_addr_in = 11'h300; if_a.wr_data_in = '0;
      end
      #1;
      exp_w = ((c % 9) == 8);
      check($sformatf("stk_rd%0d", c), 32'(if_a.rd_gnt_out), 32'(!exp_w));
      check($sformatf("stk_wr%0d", c), 32'(if_a.wr_ready_out), 32'(exp_w));
    end
    // writer drops for one cycle mid-streak: counter restarts from zero
    for (int c = 0; c < 15; c++) begin
      tick();
      if_a.wr_valid_in = (c != 5);
      #1;
      exp_w = (c == 14);
      check($sformatf("clr_rd%0d", c), 32'(if_a.rd_gnt_out), 32'(!exp_w));
      check($sformatf("clr_wr%0d", c), 32'(if_a.wr_ready_out), 32'(exp_w));
    end
    tick();
    idle_inputs();
    #1;
    check("force_wr_wea",  32'(if_a.ram_write_enable_out), 1);
    check("force_wr_addr", 32'(if_a.ram_addr_out), 32'({WR_FLIP, 11'h300}));
    repeat (4) tick();

    // 16 back-to-back reads into both DUTs (latency 1 and 2)
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c < 16) begin
        if_a.rd_req_in = 1'b1; if_a.rd_addr_in = 11'h010 + 11'(c);
        if_b.rd_req_in = 1'b1; if_b.rd_addr_in = 11'h010 + 11'(c);
      end else begin
        if_a.rd_req_in = 1'b0;
        if_b.rd_req_in = 1'b0;
      end
      #1;
      va = (c >= 2) && (c < 18);
      vb = (c >= 3) && (c < 19);
      check($sformatf("b2b_gnt%0d", c), 32'(if_b.rd_gnt_out), 32'(c < 16));
      check($sformatf("b2b_va%0d", c), 32'(if_a.rd_data_valid_out), 32'(va));
      check($sformatf("b2b_vb%0d", c), 32'(if_b.rd_data_valid_out), 32'(vb));
      if (va) check($sformatf("b2b_da%0d", c), 32'(if_a.rd_data_out), 32'(pat(12'h010 + c - 2)));
      if (vb) check($sformatf("b2b_db%0d", c), 32'(if_b.rd_data_out), 32'(pat(12'h010 + c - 3)));
    end
    repeat (3) tick();

    // three reads accepted, reset one cycle later: their data never returns
    for (int c = 0; c < 3; c++) begin
      tick();
      if_a.rd_req_in = 1'b1; if_a.rd_addr_in = 11'h030 + 11'(c);
      #1;
      check($sformatf("mid_gnt%0d", c), 32'(if_a.rd_gnt_out), 1);
    end
    tick();
    if_a.rd_req_in = 1'b0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    #1;
    check_all_zero("mid_rst");
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      check($sformatf("mid_novld%0d", c), 32'(if_a.rd_data_valid_out), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
